// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised memory-game core with a run-time loadable
// sequence memory, single-pass or progressive-round play, and a key timeout.
module jogo_memoria_param #(
    parameter int N       = 4,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 5000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic          modo,
    input  logic [AW-1:0] nivel,
    input  logic          carrega,
    input  logic [AW-1:0] carrega_endereco,
    input  logic [N-1:0]  carrega_dado,
    input  logic [N-1:0]  chaves,
    output logic          acertou,
    output logic          errou,
    output logic          pronto,
    output logic [N-1:0]  leds,
    output logic [3:0]    db_estado,
    output logic [AW-1:0] db_contagem,
    output logic [AW-1:0] db_rodada,
    output logic [N-1:0]  db_memoria,
    output logic [N-1:0]  db_jogada,
    output logic          db_tem_jogada,
    output logic          db_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROXIMO     = 4'h5,
        PROX_RODADA = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [AW-1:0] contagem_q, contagem_d;
    logic [AW-1:0] rodada_q, rodada_d;
    logic [AW-1:0] nivel_q, nivel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [N-1:0]  jogada_q, jogada_d;
    logic [N-1:0]  chaves_prev_q;
    logic [N-1:0]  mem [DEPTH];
    logic [N-1:0]  mem_atual;
    logic          tem_jogada;

    // A key event is a transition from no key pressed to some key pressed.
    assign tem_jogada = (chaves != '0) && (chaves_prev_q == '0);
    assign mem_atual  = mem[contagem_q];

    // Sequence memory: written only while idle, never cleared by reset.
    always_ff @(posedge clock) begin
        if (carrega && (estado_q == INICIAL)) begin
            mem[carrega_endereco] <= carrega_dado;
        end
    end

    // State and datapath registers; reset aborts any game in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q      <= INICIAL;
            contagem_q    <= '0;
            rodada_q      <= '0;
            nivel_q       <= '0;
            timer_q       <= '0;
            jogada_q      <= '0;
            chaves_prev_q <= '0;
        end else begin
            estado_q      <= estado_d;
            contagem_q    <= contagem_d;
            rodada_q      <= rodada_d;
            nivel_q       <= nivel_d;
            timer_q       <= timer_d;
            jogada_q      <= jogada_d;
            chaves_prev_q <= chaves;
        end
    end

    // Next-state and datapath updates for the game sequencer.
    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        rodada_d   = rodada_q;
        nivel_d    = nivel_q;
        timer_d    = timer_q;
        jogada_d   = jogada_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARA;
            end
            PREPARA: begin
                contagem_d = '0;
                nivel_d    = nivel;
                rodada_d   = modo ? '0 : nivel;
                timer_d    = '0;
                jogada_d   = '0;
                estado_d   = ESPERA;
            end
            ESPERA: begin
                timer_d = timer_q + 1'b1;
                // A key event takes priority over an expiring timer.
                if (tem_jogada) begin
                    jogada_d = chaves;
                    estado_d = REGISTRA;
                end else if (timer_q == TIMEOUT_M1) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                timer_d  = '0;
                estado_d = COMPARA;
            end
            COMPARA: begin
                if (jogada_q != mem_atual) begin
                    estado_d = FIM_ERRO;
                end else if ((contagem_q == rodada_q) && (rodada_q == nivel_q)) begin
                    estado_d = FIM_ACERTO;
                end else if (contagem_q == rodada_q) begin
                    estado_d = PROX_RODADA;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                contagem_d = contagem_q + 1'b1;
                estado_d   = ESPERA;
            end
            PROX_RODADA: begin
                rodada_d   = rodada_q + 1'b1;
                contagem_d = '0;
                estado_d   = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARA;
            end
            default: estado_d = INICIAL;
        endcase
    end

    assign pronto        = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO) ||
                           (estado_q == FIM_TIMEOUT);
    assign acertou       = (estado_q == FIM_ACERTO);
    assign errou         = (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
    assign db_timeout    = (estado_q == FIM_TIMEOUT);
    assign leds          = jogada_q;
    assign db_jogada     = jogada_q;
    assign db_estado     = estado_q;
    assign db_contagem   = contagem_q;
    assign db_rodada     = rodada_q;
    assign db_memoria    = mem_atual;
    assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param with a behavioural reference model.
module tb_jogo_memoria_param;

    localparam int N = 4;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int TO = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iniciar = 1'b0;
    logic          modo = 1'b0;
    logic [AW-1:0] nivel = '0;
    logic          carrega = 1'b0;
    logic [AW-1:0] carrega_endereco = '0;
    logic [N-1:0]  carrega_dado = '0;
    logic [N-1:0]  chaves = '0;
    logic          acertou, errou, pronto, db_tem_jogada, db_timeout;
    logic [N-1:0]  leds, db_memoria, db_jogada;
    logic [3:0]    db_estado;
    logic [AW-1:0] db_contagem, db_rodada;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clock = ~clock;

    jogo_memoria_param #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
        .nivel(nivel), .carrega(carrega), .carrega_endereco(carrega_endereco),
        .carrega_dado(carrega_dado), .chaves(chaves), .acertou(acertou),
        .errou(errou), .pronto(pronto), .leds(leds), .db_estado(db_estado),
        .db_contagem(db_contagem), .db_rodada(db_rodada), .db_memoria(db_memoria),
        .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout)
    );

    // Reference model: game phase numbered by its display code.
    int           m_st = 0;
    int           m_cont = 0;
    int           m_rod = 0;
    int           m_niv = 0;
    int           m_tim = 0;
    logic [N-1:0] m_jog = '0;
    logic [N-1:0] m_prev = '0;
    logic [N-1:0] m_mem [DEPTH];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_st <= 0; m_cont <= 0; m_rod <= 0; m_niv <= 0; m_tim <= 0;
            m_jog <= '0; m_prev <= '0;
        end else begin
            m_prev <= chaves;
            if (m_st == 0 && carrega) m_mem[carrega_endereco] <= carrega_dado;
            if (m_st == 0 || m_st >= 10) begin
                if (iniciar) m_st <= 1;
            end else if (m_st == 1) begin
                m_cont <= 0; m_niv <= int'(nivel);
                m_rod <= modo ? 0 : int'(nivel);
                m_tim <= 0; m_jog <= '0; m_st <= 2;
            end else if (m_st == 2) begin
                m_tim <= m_tim + 1;
                if (chaves != 0 && m_prev == 0) begin
                    m_jog <= chaves; m_st <= 3;
                end else if (m_tim + 1 == TO) begin
                    m_st <= 13;
                end
            end else if (m_st == 3) begin
                m_tim <= 0; m_st <= 4;
            end else if (m_st == 4) begin
                if (m_jog != m_mem[m_cont]) m_st <= 14;
                else if (m_cont < m_rod) m_st <= 5;
                else if (m_rod < m_niv) m_st <= 6;
                else m_st <= 10;
            end else if (m_st == 5) begin
                m_cont <= m_cont + 1; m_st <= 2;
            end else if (m_st == 6) begin
                m_rod <= m_rod + 1; m_cont <= 0; m_st <= 2;
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic fim;
        fim = (m_st == 10 || m_st == 13 || m_st == 14);
        cmp("db_estado", 32'(db_estado), 32'(m_st));
        cmp("db_contagem", 32'(db_contagem), 32'(m_cont));
        cmp("db_rodada", 32'(db_rodada), 32'(m_rod));
        cmp("db_jogada", 32'(db_jogada), 32'(m_jog));
        cmp("leds", 32'(leds), 32'(m_jog));
        cmp("db_memoria", 32'(db_memoria), 32'(m_mem[m_cont]));
        cmp("pronto", 32'(pronto), 32'(fim));
        cmp("acertou", 32'(acertou), 32'(m_st == 10));
        cmp("errou", 32'(errou), 32'(m_st == 13 || m_st == 14));
        cmp("db_timeout", 32'(db_timeout), 32'(m_st == 13));
        cmp("db_tem_jogada", 32'(db_tem_jogada), 32'(chaves != 0 && m_prev == 0));
    endtask

    // Each cycle: check outputs mid-cycle, then advance past the next edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            if (chk_en) cmp_all();
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_st(input int target, input int budget);
        int k = 0;
        while (m_st != target && k < budget) begin
            tick(1);
            k++;
        end
        cmp("wait_state", 32'(m_st), 32'(target));
    endtask

    task automatic load(input int a, input int d);
        carrega = 1'b1;
        carrega_endereco = AW'(a);
        carrega_dado = N'(d);
        tick(1);
        carrega = 1'b0;
    endtask

    task automatic start(input logic md, input int nv);
        modo = md;
        nivel = AW'(nv);
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
    endtask

    task automatic press(input int k);
        wait_st(2, 60);
        chaves = N'(k);
        tick(1);
        chaves = '0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt;
        #2 reset = 1'b0;
        #1;
        cmp("lit_rst_estado", 32'(db_estado), 32'h0);
        cmp("lit_rst_flags", {29'd0, pronto, acertou, errou}, 32'h0);
        cmp("lit_rst_timeout", 32'(db_timeout), 32'h0);
        cmp("lit_rst_contagem", 32'(db_contagem), 32'h0);
        cmp("lit_rst_rodada", 32'(db_rodada), 32'h0);
        cmp("lit_rst_jogada", 32'(db_jogada), 32'h0);
        tick(2);
        reset = 1'b1;
        tick(1);
        for (int i = 0; i < DEPTH; i++) load(i, (i < 4) ? (1 << i) : (15 - i));
        tick(1);
        chk_en = 1;

        // Single pass over 1,2,4,8.
        start(1'b0, 3);
        press(1); press(2); press(4); press(8);
        tick(2);
        cmp("lit_t1_estado", 32'(db_estado), 32'hA);
        cmp("lit_t1_pronto", 32'(pronto), 32'h1);
        cmp("lit_t1_acertou", 32'(acertou), 32'h1);
        cmp("lit_t1_errou", 32'(errou), 32'h0);
        cmp("lit_t1_contagem", 32'(db_contagem), 32'h3);

        // Progressive rounds up to position 2.
        start(1'b1, 2);
        press(1);
        tick(2);
        cmp("lit_t2_rodada1", 32'(db_rodada), 32'h1);
        cmp("lit_t2_estado", 32'(db_estado), 32'h2);
        press(1); press(2);
        tick(2);
        cmp("lit_t2_rodada2", 32'(db_rodada), 32'h2);
        press(1); press(2); press(4);
        tick(2);
        cmp("lit_t2_fim", 32'(db_estado), 32'hA);
        cmp("lit_t2_acertou", 32'(acertou), 32'h1);

        // Wrong second key.
        start(1'b0, 3);
        press(1); press(4);
        tick(2);
        cmp("lit_t3_estado", 32'(db_estado), 32'hE);
        cmp("lit_t3_errou", 32'(errou), 32'h1);
        cmp("lit_t3_contagem", 32'(db_contagem), 32'h1);
        cmp("lit_t3_jogada", 32'(db_jogada), 32'h4);
        cmp("lit_t3_memoria", 32'(db_memoria), 32'h2);

        // Timeout with no keys: count cycles spent waiting.
        start(1'b0, 3);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (db_estado == 4'h2) cnt++;
            if (db_estado == 4'hD) break;
            tick(1);
        end
        cmp("lit_t4_espera_cycles", 32'(cnt), 32'd20);
        cmp("lit_t4_estado", 32'(db_estado), 32'hD);
        cmp("lit_t4_timeout", 32'(db_timeout), 32'h1);
        cmp("lit_t4_errou_pronto", {30'd0, errou, pronto}, 32'h3);

        // Key event on the last waiting cycle beats the timeout.
        start(1'b0, 3);
        wait_st(2, 10);
        tick(19);
        chaves = 4'h1;
        tick(1);
        chaves = '0;
        cmp("lit_t4_evento_final", 32'(db_estado), 32'h3);
        wait_st(13, 80);

        // Held key: counts neither on entry nor across a second entry.
        chaves = 4'h1;
        start(1'b0, 3);
        tick(6);
        cmp("lit_t5_hold_estado", 32'(db_estado), 32'h2);
        cmp("lit_t5_hold_contagem", 32'(db_contagem), 32'h0);
        chaves = '0;
        tick(1);
        chaves = 4'h1;
        #1;
        cmp("lit_t5_tem_jogada", 32'(db_tem_jogada), 32'h1);
        tick(6);
        cmp("lit_t5_once_estado", 32'(db_estado), 32'h2);
        cmp("lit_t5_once_contagem", 32'(db_contagem), 32'h1);
        chaves = '0;
        tick(1);
        press(2); press(4); press(8);
        tick(2);
        cmp("lit_t5_fim", 32'(db_estado), 32'hA);

        // Multi-key press: match when stored, error otherwise.
        do_reset();
        load(0, 3);
        start(1'b0, 0);
        press(3);
        tick(2);
        cmp("lit_t5_multi_ok", 32'(db_estado), 32'hA);
        do_reset();
        load(0, 1);
        start(1'b0, 0);
        press(3);
        tick(2);
        cmp("lit_t5_multi_err", 32'(db_estado), 32'hE);
        cmp("lit_t5_multi_jogada", 32'(db_jogada), 32'h3);

        // Load attempt while playing, then reset in COMPARA.
        start(1'b0, 3);
        wait_st(2, 10);
        carrega = 1'b1;
        carrega_endereco = '0;
        carrega_dado = 4'h7;
        tick(2);
        carrega = 1'b0;
        cmp("lit_t6_memoria", 32'(db_memoria), 32'h1);
        press(1); press(2);
        cmp("lit_t6_compara", 32'(db_estado), 32'h4);
        reset = 1'b0;
        #1;
        cmp("lit_t6_rst_estado", 32'(db_estado), 32'h0);
        cmp("lit_t6_rst_flags", {28'd0, pronto, acertou, errou, db_timeout}, 32'h0);
        cmp("lit_t6_rst_contagem", 32'(db_contagem), 32'h0);
        cmp("lit_t6_rst_leds", 32'(leds), 32'h0);
        #1 reset = 1'b1;
        tick(1);
        start(1'b0, 3);
        press(1); press(2); press(4); press(8);
        tick(2);
        cmp("lit_t6_replay", 32'(db_estado), 32'hA);
        cmp("lit_t6_replay_acertou", 32'(acertou), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
